// File: rtl/demux1_8_sequencer.sv
// Serialises one 8-bit word onto a 1:8 demux: walks the enabled channels in
// ascending order, holding each on y/sel for DWELL cycles, then pulses done.
module demux1_8_sequencer #(
  parameter int DWELL = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic [7:0] in_mask,
  output logic       y,
  output logic [2:0] sel,
  output logic       y_valid,
  output logic       busy,
  output logic       done
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

  typedef enum logic [1:0] {IDLE, SCAN, FIN} state_t;

  state_t        state, state_nxt;
  logic [7:0]    data, data_nxt;
  logic [7:0]    mask, mask_nxt;
  logic [2:0]    sel_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          y_nxt, y_valid_nxt, busy_nxt, done_nxt;
  logic [3:0]    first_in, first_up;
  logic [7:0]    above;

  // Returns {found, index} of the lowest set bit.
  function automatic logic [3:0] first_set(input logic [7:0] m);
    first_set = 4'd0;
    for (int i = 7; i >= 0; i--)
      if (m[i]) first_set = {1'b1, 3'(i)};
  endfunction

  // Mask bits strictly above the current channel; empty once sel is 7.
  assign above    = mask & ~((8'd2 << sel) - 8'd1);
  assign first_in = first_set(in_mask);
  assign first_up = first_set(above);

  assign in_ready = (state == IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      data    <= '0;
      mask    <= '0;
      sel     <= '0;
      cnt     <= '0;
      y       <= 1'b0;
      y_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      data    <= data_nxt;
      mask    <= mask_nxt;
      sel     <= sel_nxt;
      cnt     <= cnt_nxt;
      y       <= y_nxt;
      y_valid <= y_valid_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    data_nxt  = data;
    mask_nxt  = mask;
    sel_nxt   = sel;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          data_nxt = in_data;
          mask_nxt = in_mask;
          cnt_nxt  = '0;
          if (first_in[3]) begin
            state_nxt = SCAN;
            sel_nxt   = first_in[2:0];
          end else begin
            state_nxt = FIN;
          end
        end
      end
      SCAN: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt = '0;
          if (first_up[3]) begin
            sel_nxt = first_up[2:0];
          end else begin
            state_nxt = FIN;
            sel_nxt   = 3'd0;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      FIN: begin
        state_nxt = IDLE;
        sel_nxt   = 3'd0;
      end
      default: begin
        state_nxt = IDLE;
        sel_nxt   = 3'd0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they land in registers.
  always_comb begin
    y_valid_nxt = (state_nxt == SCAN);
    busy_nxt    = (state_nxt != IDLE);
    done_nxt    = (state_nxt == FIN);
    y_nxt       = (state_nxt == SCAN) ? data_nxt[sel_nxt] : 1'b0;
  end

endmodule

// File: tb/tb_demux1_8_sequencer.sv
// Directed bench for demux1_8_sequencer; a DWELL=1 and a DWELL=3 instance
// share the same stimulus.
module tb_demux1_8_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic [7:0] in_mask = 8'h00;

  logic       rdy1, y1, yv1, busy1, done1;
  logic [2:0] sel1;
  logic       rdy3, y3, yv3, busy3, done3;
  logic [2:0] sel3;

  int checks = 0;
  int fails  = 0;

  // Observation vector: {y_valid, sel, y, busy, done, in_ready}
  logic [7:0] o1, o3, e;
  assign o1 = {yv1, sel1, y1, busy1, done1, rdy1};
  assign o3 = {yv3, sel3, y3, busy3, done3, rdy3};

  localparam logic [7:0] IDLE_V = 8'b0000_0001;
  localparam logic [7:0] FIN_V  = 8'b0000_0110;
  localparam logic [7:0] RST_V  = 8'b0000_0000;

  demux1_8_sequencer #(.DWELL(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
    .in_data(in_data), .in_mask(in_mask), .y(y1), .sel(sel1),
    .y_valid(yv1), .busy(busy1), .done(done1)
  );

  demux1_8_sequencer #(.DWELL(3)) u3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy3),
    .in_data(in_data), .in_mask(in_mask), .y(y3), .sel(sel3),
    .y_valid(yv3), .busy(busy3), .done(done3)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] scan_v(input logic [2:0] s, input logic b);
    scan_v = {1'b1, s, b, 1'b1, 2'b00};
  endfunction

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (o1 !== RST_V) begin fails++; $display("FAIL reset_d1 got %b want %b", o1, RST_V); end
    checks++;
    if (o3 !== RST_V) begin fails++; $display("FAIL reset_d3 got %b want %b", o3, RST_V); end
    rst = 1'b0;
    #1;
    checks++;
    if (o1 !== IDLE_V) begin fails++; $display("FAIL reset_idle got %b want %b", o1, IDLE_V); end
  endtask

  task automatic test_full_mask();
    logic [7:0] d = 8'hA5;
    do_reset();
    in_data = d; in_mask = 8'hFF; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      e = scan_v(3'(i), d[i]);
      checks++;
      if (o1 !== e) begin fails++; $display("FAIL full_scan%0d got %b want %b", i, o1, e); end
      tick();
    end
    checks++;
    if (o1 !== FIN_V) begin fails++; $display("FAIL full_done got %b want %b", o1, FIN_V); end
    tick();
    checks++;
    if (o1 !== IDLE_V) begin fails++; $display("FAIL full_idle got %b want %b", o1, IDLE_V); end
  endtask

  task automatic test_sparse_mask();
    do_reset();
    in_data = 8'hFF; in_mask = 8'h81; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    e = scan_v(3'd0, 1'b1);
    checks++;
    if (o1 !== e) begin fails++; $display("FAIL sparse_ch0 got %b want %b", o1, e); end
    tick();
    e = scan_v(3'd7, 1'b1);
    checks++;
    if (o1 !== e) begin fails++; $display("FAIL sparse_ch7 got %b want %b", o1, e); end
    tick();
    checks++;
    if (o1 !== FIN_V) begin fails++; $display("FAIL sparse_done got %b want %b", o1, FIN_V); end
    tick();
    checks++;
    if (o1 !== IDLE_V) begin fails++; $display("FAIL sparse_idle got %b want %b", o1, IDLE_V); end
  endtask

  task automatic test_empty_mask();
    do_reset();
    in_data = 8'hFF; in_mask = 8'h00; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (o1 !== FIN_V) begin fails++; $display("FAIL empty_done got %b want %b", o1, FIN_V); end
    tick();
    checks++;
    if (o1 !== IDLE_V) begin fails++; $display("FAIL empty_idle got %b want %b", o1, IDLE_V); end
  endtask

  task automatic test_dwell3();
    do_reset();
    in_data = 8'h04; in_mask = 8'h0C; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      e = (i < 3) ? scan_v(3'd2, 1'b1) : scan_v(3'd3, 1'b0);
      checks++;
      if (o3 !== e) begin fails++; $display("FAIL dwell3_c%0d got %b want %b", i, o3, e); end
      tick();
    end
    checks++;
    if (o3 !== FIN_V) begin fails++; $display("FAIL dwell3_done got %b want %b", o3, FIN_V); end
    tick();
    checks++;
    if (o3 !== IDLE_V) begin fails++; $display("FAIL dwell3_idle got %b want %b", o3, IDLE_V); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d = 8'hA5;
    do_reset();
    in_data = d; in_mask = 8'hFF; in_valid = 1'b1;
    tick();
    // Keep offering a different word while the first one scans.
    in_data = 8'h3C; in_mask = 8'h0F;
    for (int i = 0; i < 8; i++) begin
      e = scan_v(3'(i), d[i]);
      checks++;
      if (o1 !== e) begin fails++; $display("FAIL hold_scan%0d got %b want %b", i, o1, e); end
      tick();
    end
    checks++;
    if (o1 !== FIN_V) begin fails++; $display("FAIL hold_done got %b want %b", o1, FIN_V); end
    tick();
    checks++;
    if (o1 !== IDLE_V) begin fails++; $display("FAIL hold_idle got %b want %b", o1, IDLE_V); end
    tick();
    in_valid = 1'b0;
    e = scan_v(3'd0, 1'b0);
    checks++;
    if (o1 !== e) begin fails++; $display("FAIL next_ch0 got %b want %b", o1, e); end
    tick();
    tick();
    e = scan_v(3'd2, 1'b1);
    checks++;
    if (o1 !== e) begin fails++; $display("FAIL next_ch2 got %b want %b", o1, e); end
  endtask

  task automatic test_mid_reset();
    logic [7:0] d = 8'hA5;
    do_reset();
    in_data = d; in_mask = 8'hFF; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    e = scan_v(3'd2, d[2]);
    checks++;
    if (o1 !== e) begin fails++; $display("FAIL abort_pre got %b want %b", o1, e); end
    rst = 1'b1;
    #1;
    checks++;
    if (rdy1 !== 1'b0) begin fails++; $display("FAIL abort_rdy got %b want 0", rdy1); end
    tick();
    checks++;
    if (o1 !== RST_V) begin fails++; $display("FAIL abort_rst got %b want %b", o1, RST_V); end
    rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (o1 !== IDLE_V) begin fails++; $display("FAIL abort_idle%0d got %b want %b", i, o1, IDLE_V); end
      tick();
    end
    in_data = 8'h01; in_mask = 8'h01; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    e = scan_v(3'd0, 1'b1);
    checks++;
    if (o1 !== e) begin fails++; $display("FAIL after_ch0 got %b want %b", o1, e); end
    tick();
    checks++;
    if (o1 !== FIN_V) begin fails++; $display("FAIL after_done got %b want %b", o1, FIN_V); end
  endtask

  initial begin
    test_reset();
    test_full_mask();
    test_sparse_mask();
    test_empty_mask();
    test_dwell3();
    test_back_to_back();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
